// File: rtl/bar_writer.sv
// Shadow bar-height store for the visualizer: peak-hold/clamped updates via valid/ready,
// one flush of every bar per frame at vertical blanking, then a saturating linear decay.
module bar_writer #(
  parameter  int SCREEN_HEIGHT = 42,
  parameter  int MAX_HEIGHT    = 1024,
  parameter  int DECAY         = 4,
  parameter  int BLANK_START   = 720,
  localparam int AW            = $clog2(SCREEN_HEIGHT)
) (
  input  logic          pixel_clk_in,
  input  logic          rst_n_in,
  input  logic [10:0]   hcount_in,
  input  logic [9:0]    vcount_in,
  input  logic          upd_valid_in,
  output logic          upd_ready_out,
  input  logic [AW-1:0] upd_addr_in,
  input  logic [31:0]   upd_value_in,
  output logic          tg_write_en,
  output logic [AW-1:0] tg_addr,
  output logic [31:0]   tg_input,
  output logic          busy_out
);

  localparam int          IW   = $clog2(SCREEN_HEIGHT + 1);
  localparam logic [31:0] MAXH = 32'(MAX_HEIGHT);
  localparam logic [31:0] DEC  = 32'(DECAY);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_DECAY} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   bars_q [SCREEN_HEIGHT];
  logic [31:0]   bars_d [SCREEN_HEIGHT];
  logic          wen_q, wen_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          accept;
  logic          trigger;
  logic [31:0]   clamped;

  assign upd_ready_out = rst_n_in && (state_q == S_IDLE);
  assign busy_out      = (state_q != S_IDLE);
  assign tg_write_en   = wen_q;
  assign tg_addr       = addr_q;
  assign tg_input      = data_q;

  assign accept  = upd_valid_in && upd_ready_out;
  assign trigger = (hcount_in == '0) && (vcount_in == 10'(BLANK_START));
  assign clamped = (upd_value_in > MAXH) ? MAXH : upd_value_in;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    data_d  = data_q;
    bars_d  = bars_q;

    if (accept && (32'(upd_addr_in) < 32'(SCREEN_HEIGHT))) begin
      if (clamped > bars_q[upd_addr_in]) begin
        bars_d[upd_addr_in] = clamped;
      end
    end

    case (state_q)
      S_IDLE: begin
        // Entry 0 is issued on the trigger edge itself, from the post-update
        // array, so a same-cycle update reaches the first write.
        if (trigger) begin
          wen_d   = 1'b1;
          addr_d  = '0;
          data_d  = bars_d[0];
          idx_d   = IW'(1);
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (idx_q < IW'(SCREEN_HEIGHT)) begin
          wen_d  = 1'b1;
          addr_d = AW'(idx_q);
          data_d = bars_q[idx_q];
          idx_d  = idx_q + IW'(1);
        end else begin
          wen_d   = 1'b0;
          state_d = S_DECAY;
        end
      end
      S_DECAY: begin
        for (int unsigned i = 0; i < SCREEN_HEIGHT; i++) begin
          bars_d[i] = (bars_q[i] > DEC) ? bars_q[i] - DEC : '0;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      for (int unsigned i = 0; i < SCREEN_HEIGHT; i++) begin
        bars_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      bars_q  <= bars_d;
    end
  end

endmodule

// File: tb/tb_bar_writer.sv
// Randomized self-checking bench for bar_writer against an array-based model of the bar store.
module tb_bar_writer;

  localparam int NB   = 42;
  localparam int MAXH = 1024;
  localparam int DEC  = 4;

  logic        clk;
  logic        rst_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        upd_valid;
  logic        upd_ready;
  logic [5:0]  upd_addr;
  logic [31:0] upd_value;
  logic        tg_write_en;
  logic [5:0]  tg_addr;
  logic [31:0] tg_input;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [NB];

  bar_writer #(
    .SCREEN_HEIGHT(NB),
    .MAX_HEIGHT   (MAXH),
    .DECAY        (DEC),
    .BLANK_START  (720)
  ) dut (
    .pixel_clk_in (clk),
    .rst_n_in     (rst_n),
    .hcount_in    (hcount),
    .vcount_in    (vcount),
    .upd_valid_in (upd_valid),
    .upd_ready_out(upd_ready),
    .upd_addr_in  (upd_addr),
    .upd_value_in (upd_value),
    .tg_write_en  (tg_write_en),
    .tg_addr      (tg_addr),
    .tg_input     (tg_input),
    .busy_out     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void mdl_upd(input int a, input logic [31:0] v);
    logic [31:0] c;
    if (a >= NB) return;
    c = (v > 32'(MAXH)) ? 32'(MAXH) : v;
    if (c > model[a]) model[a] = c;
  endfunction

  function automatic void mdl_decay();
    for (int i = 0; i < NB; i++)
      model[i] = (model[i] > 32'(DEC)) ? model[i] - 32'(DEC) : 32'd0;
  endfunction

  function automatic void mdl_clear();
    for (int i = 0; i < NB; i++) model[i] = '0;
  endfunction

  task automatic do_upd(input int a, input logic [31:0] v);
    upd_valid = 1'b1;
    upd_addr  = 6'(a);
    upd_value = v;
    check("upd_ready", 32'(upd_ready), 32'd1);
    mdl_upd(a, v);
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  // Called at a negedge; the following posedge is the trigger edge T.
  task automatic do_frame(input bit same_upd, input int ua, input logic [31:0] uv,
                          input bit hold, input int rst_after);
    logic [31:0] exp_q [NB];
    hcount = '0;
    vcount = 10'd720;
    if (same_upd) begin
      upd_valid = 1'b1;
      upd_addr  = 6'(ua);
      upd_value = uv;
      check("trig_ready", 32'(upd_ready), 32'd1);
      mdl_upd(ua, uv);
    end
    exp_q = model;
    @(negedge clk);
    hcount    = 11'd5;
    vcount    = 10'd721;
    upd_valid = 1'b0;
    if (hold) begin
      upd_valid = 1'b1;
      upd_addr  = 6'(ua);
      upd_value = uv;
    end
    for (int k = 0; k < NB; k++) begin
      if (k == rst_after) begin
        rst_n = 1'b0;
        #1;
        check("rst_wen", 32'(tg_write_en), 32'd0);
        check("rst_ready", 32'(upd_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        mdl_clear();
        @(negedge clk);
        @(negedge clk);
        check("rst_wen_hold", 32'(tg_write_en), 32'd0);
        rst_n = 1'b1;
        upd_valid = 1'b0;
        vcount = '0;
        @(negedge clk);
        check("rst_rel_ready", 32'(upd_ready), 32'd1);
        return;
      end
      check("fl_wen", 32'(tg_write_en), 32'd1);
      check("fl_addr", 32'(tg_addr), 32'(k));
      check("fl_data", tg_input, exp_q[k]);
      check("fl_ready", 32'(upd_ready), 32'd0);
      check("fl_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    check("dec_wen", 32'(tg_write_en), 32'd0);
    check("dec_ready", 32'(upd_ready), 32'd0);
    check("dec_busy", 32'(busy), 32'd1);
    mdl_decay();
    @(negedge clk);
    check("post_ready", 32'(upd_ready), 32'd1);
    check("post_busy", 32'(busy), 32'd0);
    if (hold) begin
      mdl_upd(ua, uv);
      @(negedge clk);
      upd_valid = 1'b0;
    end
    vcount = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    hcount    = 11'd5;
    vcount    = '0;
    upd_valid = 1'b0;
    upd_addr  = '0;
    upd_value = '0;
    mdl_clear();

    @(negedge clk);
    check("rst_ready", 32'(upd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wen", 32'(tg_write_en), 32'd0);
    check("rst_addr", 32'(tg_addr), 32'd0);
    check("rst_data", tg_input, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'(upd_ready), 32'd1);

    // Empty frame
    do_frame(1'b0, 0, 0, 1'b0, -1);

    // Clamp and peak-hold
    do_upd(5, 300);
    do_upd(5, 100);
    do_upd(7, 5000);
    do_frame(1'b0, 0, 0, 1'b0, -1);
    check("peak_b5_decayed", model[5], 32'd296);

    // Decay to saturation
    do_upd(3, 10);
    for (int f = 0; f < 4; f++) do_frame(1'b0, 0, 0, 1'b0, -1);
    check("decay_b3_zero", model[3], 32'd0);

    // Update held through a flush lands afterwards
    do_frame(1'b0, 2, 50, 1'b1, -1);
    check("hold_b2", model[2], 32'd50);
    do_frame(1'b0, 0, 0, 1'b0, -1);

    // Same-cycle update and trigger, then out-of-range address
    do_frame(1'b1, 0, 77, 1'b0, -1);
    do_upd(50, 999);
    do_upd(41, 32'hFFFF_FFFF);
    do_frame(1'b0, 0, 0, 1'b0, -1);

    // Randomized frames
    for (int f = 0; f < 12; f++) begin
      int n;
      n = $urandom_range(0, 8);
      for (int u = 0; u < n; u++) begin
        logic [31:0] v;
        v = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 1500));
        do_upd($urandom_range(0, 47), v);
        if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
      if ($urandom_range(0, 2) == 0)
        do_frame(1'b1, $urandom_range(0, 47), 32'($urandom_range(0, 2000)), 1'b0, -1);
      else
        do_frame(1'b0, 0, 0, 1'b0, -1);
    end

    // Reset after the 10th write, then a clean frame
    do_upd(9, 500);
    do_upd(20, 600);
    do_frame(1'b0, 0, 0, 1'b0, 10);
    do_frame(1'b0, 0, 0, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
